// File: rtl/mem_access_unit.sv
// mem_access_unit: memory access sequencer that sits after addr_mux4.
// On an accepted start it latches the address and write data. It holds the
// memory enable for MEM_LAT cycles, then pulses done for one cycle. For reads
// it also returns the captured read word on dataOut.
// Optional feature: define ADDR_RANGE_CHECK_EN to reject addresses >= MEM_DEPTH.
module mem_access_unit #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 2,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] memRData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memEn,
  output logic              memWe,
  output logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output logic              done,
  output logic              errFlag
);

  // A latency below one cycle makes no sense, so it is clamped to a single cycle.
  localparam int LAT   = (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_isWrite;

  logic w_singleOp;
  logic w_bothOps;
  logic w_addrOk;

  assign w_singleOp = memRead ^ memWrite;
  assign w_bothOps  = memRead & memWrite;

`ifdef ADDR_RANGE_CHECK_EN
  // Addresses beyond the populated memory are refused before any cycle starts.
  assign w_addrOk = (32'(addrIn) < 32'(MEM_DEPTH));
`else
  assign w_addrOk = 1'b1;
`endif

  // Sequencer: accepts a request in IDLE, holds the enable for LAT cycles, then pulses done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_isWrite <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      memEn     <= 1'b0;
      memWe     <= 1'b0;
      dataOut   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      errFlag   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && w_singleOp && w_addrOk) begin
            memAddr   <= addrIn;
            memWData  <= dataIn;
            r_isWrite <= memWrite;
            r_cnt     <= CNT_W'(LAT - 1);
            errFlag   <= 1'b0;
            busy      <= 1'b1;
            memEn     <= 1'b1;
            memWe     <= memWrite;
            r_state   <= ACCESS;
          end else if (start && (w_bothOps || (w_singleOp && !w_addrOk))) begin
            errFlag <= 1'b1;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            if (!r_isWrite) begin
              dataOut <= memRData;
            end
            memEn   <= 1'b0;
            memWe   <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          memEn   <= 1'b0;
          memWe   <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table vectors, hand-written corner sequences
// and randomized transactions checked against a transaction-level model.
module tb_mem_access_unit;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 16;
  localparam int MEM_LAT   = 2;
  localparam int MEM_DEPTH = 512;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] addrIn;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] memRData;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic              memEn;
  logic              memWe;
  logic [DATA_W-1:0] dataOut;
  logic              busy;
  logic              done;
  logic              errFlag;

  int checkCount;
  int passCount;

  // Model of the architecturally visible state between transactions.
  logic [DATA_W-1:0] expData;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expWData;
  logic              expErr;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rdata;
    bit                poke;
    logic              expErr;
    logic [DATA_W-1:0] expDataOut;
  } vec_t;

  vec_t vecs[8];

  mem_access_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_LAT  (MEM_LAT),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .memRead (memRead),
    .memWrite(memWrite),
    .addrIn  (addrIn),
    .dataIn  (dataIn),
    .memRData(memRData),
    .memAddr (memAddr),
    .memWData(memWData),
    .memEn   (memEn),
    .memWe   (memWe),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done),
    .errFlag (errFlag)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check that the unit is sitting idle with the modelled held values.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_memEn"}, 32'(memEn), 32'd0);
    checkOutput({tag, "_memWe"}, 32'(memWe), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(errFlag), 32'(expErr));
    checkOutput({tag, "_dataOut"}, 32'(dataOut), 32'(expData));
    checkOutput({tag, "_memAddr"}, 32'(memAddr), 32'(expAddr));
    checkOutput({tag, "_memWData"}, 32'(memWData), 32'(expWData));
  endtask

  // Issue one request in IDLE and follow it to completion, checking every cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rdata, input bit poke);
    bit accept;
    bit reject;
    accept = rd ^ wr;
    reject = rd & wr;
`ifdef ADDR_RANGE_CHECK_EN
    if (accept && (int'(a) >= MEM_DEPTH)) begin
      accept = 1'b0;
      reject = 1'b1;
    end
`endif
    start    = 1'b1;
    memRead  = rd;
    memWrite = wr;
    addrIn   = a;
    dataIn   = d;
    memRData = rdata;
    tick();
    start    = 1'b0;
    addrIn   = ADDR_W'($urandom);
    dataIn   = DATA_W'($urandom);
    memRead  = 1'($urandom);
    memWrite = 1'($urandom);
    if (accept) begin
      expAddr  = a;
      expWData = d;
      expErr   = 1'b0;
      for (int c = 0; c < MEM_LAT; c++) begin
        checkOutput("acc_memEn", 32'(memEn), 32'd1);
        checkOutput("acc_memWe", 32'(memWe), 32'(wr));
        checkOutput("acc_busy", 32'(busy), 32'd1);
        checkOutput("acc_done", 32'(done), 32'd0);
        checkOutput("acc_memAddr", 32'(memAddr), 32'(expAddr));
        checkOutput("acc_memWData", 32'(memWData), 32'(expWData));
        checkOutput("acc_err", 32'(errFlag), 32'd0);
        start  = poke;
        addrIn = ADDR_W'($urandom);
        tick();
      end
      if (!wr) begin
        expData = rdata;
      end
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd1);
      checkOutput("done_memEn", 32'(memEn), 32'd0);
      checkOutput("done_memWe", 32'(memWe), 32'd0);
      checkOutput("done_dataOut", 32'(dataOut), 32'(expData));
      checkOutput("done_memAddr", 32'(memAddr), 32'(expAddr));
      tick();
      start = 1'b0;
      checkIdle("post");
    end else begin
      if (reject) begin
        expErr = 1'b1;
      end
      checkIdle("noacc");
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    expData    = '0;
    expAddr    = '0;
    expWData   = '0;
    expErr     = 1'b0;
    reset_n    = 1'b0;
    start      = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    addrIn     = '0;
    dataIn     = '0;
    memRData   = '0;

    vecs[0] = '{1'b1, 1'b0, 10'd512, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 10'd3,   16'h1234, 16'h5555, 1'b0, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 10'd7,   16'h9999, 16'h7777, 1'b0, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 10'd9,   16'h8888, 16'h6666, 1'b0, 1'b1, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 10'd100, 16'h0000, 16'hCAFE, 1'b1, 1'b0, 16'hCAFE};
`ifdef ADDR_RANGE_CHECK_EN
    vecs[0] = '{1'b1, 1'b0, 10'd500, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 10'd512, 16'h0000, 16'h0A5A, 1'b0, 1'b1, 16'hCAFE};
    vecs[6] = '{1'b1, 1'b0, 10'd511, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h1111};
    vecs[7] = '{1'b0, 1'b1, 10'd1023, 16'hFFFF, 16'h2222, 1'b0, 1'b1, 16'h1111};
`else
    vecs[5] = '{1'b1, 1'b0, 10'd600, 16'h0000, 16'h0A5A, 1'b0, 1'b0, 16'h0A5A};
    vecs[6] = '{1'b1, 1'b0, 10'd511, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h1111};
    vecs[7] = '{1'b0, 1'b1, 10'd1023, 16'hFFFF, 16'h2222, 1'b0, 1'b0, 16'h1111};
`endif

    #12;
    checkIdle("reset");
    tick();
    reset_n = 1'b1;
    tick();
    checkIdle("reset_rel");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rdata, vecs[i].poke);
      checkOutput($sformatf("tbl%0d_err", i), 32'(errFlag), 32'(vecs[i].expErr));
      checkOutput($sformatf("tbl%0d_dataOut", i), 32'(dataOut), 32'(vecs[i].expDataOut));
    end

    // Error then recovery: a rejected request sets errFlag, the next good read clears it.
    applyStimulus(1'b1, 1'b1, 10'd20, 16'h0001, 16'h0002, 1'b0);
    checkOutput("seq_err_set", 32'(errFlag), 32'd1);
    applyStimulus(1'b1, 1'b0, 10'd21, 16'h0003, 16'h4321, 1'b0);
    checkOutput("seq_err_clr", 32'(errFlag), 32'd0);

    // Reset in the middle of a write must drop the enables immediately and suppress done.
    start    = 1'b1;
    memWrite = 1'b1;
    memRead  = 1'b0;
    addrIn   = 10'd5;
    dataIn   = 16'hABCD;
    tick();
    start = 1'b0;
    checkOutput("mid_memWe", 32'(memWe), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    expData  = '0;
    expAddr  = '0;
    expWData = '0;
    expErr   = 1'b0;
    checkIdle("async_rst");
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_no_done", 32'(done), 32'd0);
    end
    reset_n  = 1'b1;
    memWrite = 1'b0;
    tick();
    checkIdle("after_rst");

    // Randomized transactions against the model.
    for (int n = 0; n < 200; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      applyStimulus(1'(op == 1 || op == 3), 1'(op == 2 || op == 3), ADDR_W'($urandom),
                    DATA_W'($urandom), DATA_W'($urandom), bit'($urandom_range(0, 1)));
      start    = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        tick();
        checkIdle("rnd_gap");
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory access sequencer sitting directly downstream of addr_mux4.
- Latches the selected 10-bit address (addr_mux4 dataOut) plus write data on a start request, then drives a synchronous memory for a fixed number of wait cycles.
- Returns read data with a one-cycle done pulse.
- Lets the multicycle controller change the mux select freely once a request is accepted.

Parameters:
- ADDR_W, 10, address width; matches addr_mux4 data width.
- DATA_W, 16, data word width.
- MEM_LAT, 2, cycles memEn is held per access. Values <1 are treated as 1.
- MEM_DEPTH, 1024, number of valid addresses. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe, sampled in IDLE only.
- memRead  in  1  read request qualifier.
- memWrite  in  1  write request qualifier.
- addrIn  in  ADDR_W  address from addr_mux4 dataOut.
- dataIn  in  DATA_W  write data.
- memRData  in  DATA_W  memory read data, valid while memEn is high.
- memAddr  out  ADDR_W  registered address to memory.
- memWData  out  DATA_W  registered write data.
- memEn  out  1  memory enable.
- memWe  out  1  memory write enable.
- dataOut  out  DATA_W  last read word, held.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- errFlag  out  1  sticky request error.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including memAddr, memWData, dataOut and errFlag.
  - Wait counter goes to 0.
  - memEn and memWe drop immediately, including mid-access. No done is generated for an aborted access.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - busy=0, memEn=0, memWe=0, done=0.
  - start=1 with exactly one of memRead/memWrite set (accepted request):
    - Latch addrIn into memAddr and dataIn into memWData.
    - Record the op.
    - Load the counter with MEM_LAT-1.
    - Clear errFlag.
    - Go to ACCESS.
  - start=1 with both memRead and memWrite set: reject, set errFlag, stay in IDLE.
  - start=1 with neither set: ignore, errFlag unchanged.
- ACCESS:
  - busy=1, memEn=1, memWe=1 for writes only.
  - Counter decrements each cycle.
  - When the counter is 0:
    - For reads, capture memRData into dataOut on that edge.
    - Go to DONE.
  - ACCESS therefore lasts exactly MEM_LAT cycles.
- DONE:
  - busy=1, done=1, memEn=0, memWe=0.
  - Unconditionally go to IDLE next cycle.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+MEM_LAT. Next request can be accepted at edge E0+MEM_LAT+2.
- start asserted during ACCESS or DONE is ignored: not queued, no error.
- addrIn, dataIn, memRead and memWrite may change freely after acceptance. memAddr and memWData stay stable until the next accepted request.
- dataOut holds its value across writes and rejected requests. It changes only on read completion.
- memAddr and memWData hold their last values in IDLE.

Optional Feature:
- Macro: ADDR_RANGE_CHECK_EN.
- Defined:
  - In IDLE, a start with a valid single op but addrIn >= MEM_DEPTH is rejected.
  - errFlag is set and state stays IDLE.
  - No memory cycle occurs; memAddr and memWData are not updated.
- Not defined: no range comparison; every address is accepted; MEM_DEPTH has no effect.

Test Plan:
- Reset check: reset_n=0 mid-ACCESS of a write to 10'd5 -> memEn=0 and memWe=0 immediately; busy=0; no done pulse; all outputs 0.
- Read, MEM_LAT=2: addrIn=10'd512, memRead=1, start pulse at E0, memRData=16'hBEEF -> memAddr=512 and memEn=1 after E0 and E1; done=1 and dataOut=16'hBEEF after E2; busy=0 after E3.
- Write: addrIn=10'd3, dataIn=16'h1234, memWrite=1, start pulse -> memWe=1 for exactly 2 cycles with memWData=16'h1234; dataOut unchanged.
- Address stability: change addrIn to 10'd7 one cycle after accepting 10'd100 -> memAddr stays 100 through DONE.
- Error and ignore: start with memRead=memWrite=1 -> errFlag=1, memEn stays 0. Next valid read -> errFlag=0. start pulsed during ACCESS -> ignored, exactly one done.
- With ADDR_RANGE_CHECK_EN and MEM_DEPTH=512: read of 10'd512 -> errFlag=1, no memEn. Read of 10'd511 -> normal completion.
